game_controller: RTL
====================

GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter: BOARD_N, default 8, board edge length in cells; only 8 is supported.
REQ-002 clk  in  1  system clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  single-cycle pulse; begins a new game.
REQ-005 bomb_matrix  in  [7:0][7:0]  bomb map, bit [y][x]=1 means bomb; sampled only on accepted start.
REQ-006 bomb_total  in  6  bomb count of bomb_matrix; sampled only on accepted start.
REQ-007 cur_x, cur_y  in  4 each  cursor cell from the movement controller; values 8..15 are out of range.
REQ-008 cmd_valid  in  1  command request, held until accepted.
REQ-009 cmd_op  in  2  00 reveal, 01 toggle flag, 10/11 reserved.
REQ-010 cmd_ready  out  1  command accepted on a cycle where cmd_valid and cmd_ready are both 1.
REQ-011 revealed  out  [7:0][7:0]  revealed-cell mask.
REQ-012 flagged  out  [7:0][7:0]  flagged-cell mask.
REQ-013 adj_count  out  4  neighbour-bomb count of the last revealed safe cell, 0..8.
REQ-014 count_done  out  1  one-cycle pulse when adj_count updates.
REQ-015 game_state  out  3  IDLE=0, PLAY=1, COUNT=2, WIN=3, LOSE=4.

Function
REQ-016 States: IDLE, PLAY, COUNT, WIN, LOSE; cmd_ready=1 only in PLAY.
REQ-017 start in IDLE/WIN/LOSE: latch bomb_matrix and bomb_total, clear revealed, flagged, adj_count and revealed_cnt, go to PLAY next cycle; start in PLAY/COUNT is ignored.
REQ-018 Accepted commands with cur_x or cur_y >7, or reserved op: no state change.
REQ-019 Reveal on an already revealed or flagged cell: no state change, remain PLAY.
REQ-020 Reveal on a bomb cell: set its revealed bit, go to LOSE next cycle; adj_count unchanged.
REQ-021 Reveal on a safe cell: latch coordinates, go to COUNT, clear 4-bit accumulator.
REQ-022 COUNT runs exactly 8 cycles, k=0..7, one neighbour per cycle, order (dx,dy): (-1,-1),(0,-1),(+1,-1),(-1,0),(+1,0),(-1,+1),(0,+1),(+1,+1).
REQ-023 Neighbours outside 0..7 on either axis contribute 0; no wrap-around.
REQ-024 Cycle after k=7: adj_count=accumulator, count_done=1, revealed bit set, revealed_cnt incremented (7-bit).
REQ-025 Same cycle: if revealed_cnt (new) == 64-bomb_total, go to WIN, else PLAY.
REQ-026 Latency: reveal accepted at edge T, count_done high in cycle T+9, cmd_ready high again at T+10 unless WIN.
REQ-027 bomb_total=0 reaches WIN only after all 64 cells revealed; a latched bomb_total inconsistent with bomb_matrix is not checked.
REQ-028 WIN and LOSE hold all outputs until start or reset.

Reset
REQ-029 reset low asynchronously forces IDLE, revealed=0, flagged=0, adj_count=0, count_done=0, revealed_cnt=0, latched matrix=0; cmd_ready=0.
REQ-030 reset asserted mid-COUNT aborts the scan; no partial reveal survives.

Configuration
REQ-031 Macro GAME_CONTROLLER_FLAG_EN defined: op 01 in PLAY toggles flagged bit of an unrevealed in-range cell; on a revealed cell no effect.
REQ-032 Macro GAME_CONTROLLER_FLAG_EN undefined: flagged tied to 0, op 01 accepted with no effect, flag registers not built.

Verification
REQ-033 reset low mid-run -> game_state=0, revealed=0, cmd_ready=0 immediately, no clock needed.
REQ-034 Bombs at (0,0),(1,0),(0,1); start, reveal (1,1) -> count_done at T+9, adj_count=3, revealed[1][1]=1, state PLAY.
REQ-035 Corner check: bomb at (7,7) only; reveal (0,0) -> adj_count=0; reveal (6,6) -> adj_count=1.
REQ-036 Reveal bomb cell (0,0) -> state LOSE next cycle, cmd_ready=0, further cmd_valid ignored; start -> PLAY, masks cleared.
REQ-037 63 bombs, one safe cell (3,4); reveal (3,4) -> count_done then state WIN; second reveal never accepted.
REQ-038 With GAME_CONTROLLER_FLAG_EN: flag (2,2), reveal (2,2) -> no change; flag again, reveal -> COUNT entered.

Source files
------------

// File: rtl/game_controller_if.sv
// Game controller bus: start/board load, cursor command handshake and board status.
interface game_controller_if;
  logic             start;
  logic [7:0][7:0]  bomb_matrix;
  logic [5:0]       bomb_total;
  logic [3:0]       cur_x;
  logic [3:0]       cur_y;
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic             cmd_ready;
  logic [7:0][7:0]  revealed;
  logic [7:0][7:0]  flagged;
  logic [3:0]       adj_count;
  logic             count_done;
  logic [2:0]       game_state;

  modport master (
    output start, bomb_matrix, bomb_total, cur_x, cur_y, cmd_valid, cmd_op,
    input  cmd_ready, revealed, flagged, adj_count, count_done, game_state
  );

  modport slave (
    input  start, bomb_matrix, bomb_total, cur_x, cur_y, cmd_valid, cmd_op,
    output cmd_ready, revealed, flagged, adj_count, count_done, game_state
  );
endinterface

// File: rtl/game_controller.sv
// Minesweeper game controller: reveal/flag commands, 8-cycle neighbour scan, win/lose tracking.
// Optional flagging is built only when GAME_CONTROLLER_FLAG_EN is defined.
module game_controller #(
  parameter int unsigned BOARD_N = 8
) (
  input logic              clk,
  input logic              reset,
  game_controller_if.slave bus
);
  localparam int unsigned CELL_CNT = BOARD_N * BOARD_N;
  localparam int unsigned CNT_W    = 7;
  localparam int unsigned K_W      = 4;
  localparam logic [K_W-1:0] K_DONE = K_W'(8);
  localparam logic [4:0] NEG1 = 5'h1F;
  localparam logic [4:0] POS1 = 5'h01;
  localparam logic [1:0] OP_REVEAL = 2'b00;
`ifdef GAME_CONTROLLER_FLAG_EN
  localparam logic [1:0] OP_FLAG = 2'b01;
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    COUNT = 3'd2,
    WIN   = 3'd3,
    LOSE  = 3'd4
  } state_t;

  state_t           state_q, state_nxt;
  logic [7:0][7:0]  bombs_q, bombs_nxt;
  logic [7:0][7:0]  revealed_q, revealed_nxt;
  logic [5:0]       total_q, total_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [2:0]       cx_q, cx_nxt, cy_q, cy_nxt;
  logic [K_W-1:0]   k_q, k_nxt;
  logic [3:0]       acc_q, acc_nxt, adj_q, adj_nxt;
  logic             done_q, done_nxt, ready_q, ready_nxt;
  logic [7:0][7:0]  flags;

`ifdef GAME_CONTROLLER_FLAG_EN
  logic [7:0][7:0]  flagged_q, flagged_nxt;
  assign flags = flagged_q;
`else
  assign flags = '0;
`endif

  logic             cmd_fire, in_range;
  logic [2:0]       px, py;
  logic [4:0]       dx, dy, nx, ny;
  logic             nb_bomb;
  logic [CNT_W-1:0] win_target;

  assign cmd_fire   = bus.cmd_valid && ready_q;
  assign in_range   = !bus.cur_x[3] && !bus.cur_y[3];
  assign px         = bus.cur_x[2:0];
  assign py         = bus.cur_y[2:0];
  assign win_target = CNT_W'(CELL_CNT) - {1'b0, total_q};

  // Neighbour offset for scan step k
  always_comb begin
    dx = 5'd0;
    dy = 5'd0;
    case (k_q[2:0])
      3'd0:    begin dx = NEG1; dy = NEG1; end
      3'd1:    dy = NEG1;
      3'd2:    begin dx = POS1; dy = NEG1; end
      3'd3:    dx = NEG1;
      3'd4:    dx = POS1;
      3'd5:    begin dx = NEG1; dy = POS1; end
      3'd6:    dy = POS1;
      default: begin dx = POS1; dy = POS1; end
    endcase
  end

  // Off-board neighbours land at -1 or 8 and fail the range test
  assign nx      = {2'b00, cx_q} + dx;
  assign ny      = {2'b00, cy_q} + dy;
  assign nb_bomb = (nx[4:3] == 2'b00) && (ny[4:3] == 2'b00) && bombs_q[ny[2:0]][nx[2:0]];

  always_comb begin
    state_nxt    = state_q;
    bombs_nxt    = bombs_q;
    revealed_nxt = revealed_q;
    total_nxt    = total_q;
    cnt_nxt      = cnt_q;
    cx_nxt       = cx_q;
    cy_nxt       = cy_q;
    k_nxt        = k_q;
    acc_nxt      = acc_q;
    adj_nxt      = adj_q;
    done_nxt     = 1'b0;
`ifdef GAME_CONTROLLER_FLAG_EN
    flagged_nxt  = flagged_q;
`endif
    case (state_q)
      IDLE, WIN, LOSE: begin
        if (bus.start) begin
          bombs_nxt    = bus.bomb_matrix;
          total_nxt    = bus.bomb_total;
          revealed_nxt = '0;
          cnt_nxt      = '0;
          adj_nxt      = '0;
`ifdef GAME_CONTROLLER_FLAG_EN
          flagged_nxt  = '0;
`endif
          state_nxt    = PLAY;
        end
      end
      PLAY: begin
        if (cmd_fire && in_range) begin
          if (bus.cmd_op == OP_REVEAL) begin
            if (!revealed_q[py][px] && !flags[py][px]) begin
              if (bombs_q[py][px]) begin
                revealed_nxt[py][px] = 1'b1;
                state_nxt            = LOSE;
              end else begin
                cx_nxt    = px;
                cy_nxt    = py;
                k_nxt     = '0;
                acc_nxt   = '0;
                state_nxt = COUNT;
              end
            end
          end
`ifdef GAME_CONTROLLER_FLAG_EN
          else if (bus.cmd_op == OP_FLAG && !revealed_q[py][px]) begin
            flagged_nxt[py][px] = ~flagged_q[py][px];
          end
`endif
        end
      end
      COUNT: begin
        if (k_q != K_DONE) begin
          acc_nxt = acc_q + 4'(nb_bomb);
          k_nxt   = k_q + K_W'(1);
        end else begin
          adj_nxt                = acc_q;
          done_nxt               = 1'b1;
          revealed_nxt[cy_q][cx_q] = 1'b1;
          cnt_nxt                = cnt_q + CNT_W'(1);
          state_nxt              = (cnt_nxt == win_target) ? WIN : PLAY;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Ready only once PLAY has been held for a full cycle
    ready_nxt = (state_q == PLAY) && (state_nxt == PLAY);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bombs_q    <= '0;
      revealed_q <= '0;
      total_q    <= '0;
      cnt_q      <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      adj_q      <= '0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      bombs_q    <= bombs_nxt;
      revealed_q <= revealed_nxt;
      total_q    <= total_nxt;
      cnt_q      <= cnt_nxt;
      cx_q       <= cx_nxt;
      cy_q       <= cy_nxt;
      k_q        <= k_nxt;
      acc_q      <= acc_nxt;
      adj_q      <= adj_nxt;
      done_q     <= done_nxt;
      ready_q    <= ready_nxt;
    end
  end

`ifdef GAME_CONTROLLER_FLAG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flagged_q <= '0;
    else        flagged_q <= flagged_nxt;
  end
`endif

  assign bus.game_state = state_q;
  assign bus.cmd_ready  = ready_q;
  assign bus.revealed   = revealed_q;
  assign bus.flagged    = flags;
  assign bus.adj_count  = adj_q;
  assign bus.count_done = done_q;
endmodule
